// File: rtl/ay8913_psg_core.sv
// AY-3-8913 style tone/noise source: register file, three tone dividers, LFSR noise,
// per-channel mixer and registered 4-bit amplitude codes for the DAC.
module ay8913_psg_core #(
  parameter int unsigned PRESCALE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [3:0] vol_a,
  output logic [3:0] vol_b,
  output logic [3:0] vol_c
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned TW = 12;
  localparam int unsigned NW = 5;
  localparam int unsigned LW = 17;

  logic [PW-1:0] pre_cnt;
  logic          ntick_tgl;
  logic [7:0]    tone_fine   [3];
  logic [3:0]    tone_coarse [3];
  logic [NW-1:0] noise_per;
  logic [5:0]    mixer;
  logic [3:0]    amp         [3];
  logic [TW-1:0] tone_cnt    [3];
  logic [2:0]    tone;
  logic [NW-1:0] noise_cnt;
  logic [LW-1:0] lfsr;

  logic          tick_c;
  logic          ntick_c;
  logic [2:0]    tone_wrap_c;
  logic          noise_wrap_c;
  logic [2:0]    ch_on_c;

  // A zero period behaves as 1; >= lets a shrunken period wrap on the next tick.
  function automatic logic wraps(input logic [TW-1:0] cnt, input logic [TW-1:0] per);
    logic [TW:0] per_max;
    per_max = (per == '0) ? (TW+1)'(1) : {1'b0, per};
    return ({1'b0, cnt} + (TW+1)'(1)) >= per_max;
  endfunction

  always_comb begin
    tick_c       = ena && (pre_cnt == PW'(PRESCALE - 1));
    ntick_c      = tick_c && ntick_tgl;
    noise_wrap_c = wraps(TW'(noise_cnt), TW'(noise_per));
    tone_wrap_c  = '0;
    ch_on_c      = '0;
    for (int i = 0; i < 3; i++) begin
      tone_wrap_c[i] = wraps(tone_cnt[i], {tone_coarse[i], tone_fine[i]});
      ch_on_c[i]     = (tone[i] | mixer[i]) & (lfsr[0] | mixer[i+3]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt   <= '0;
      ntick_tgl <= 1'b0;
      noise_per <= '0;
      mixer     <= 6'h3F;
      noise_cnt <= '0;
      lfsr      <= LW'(1);
      tone      <= '0;
      vol_a     <= '0;
      vol_b     <= '0;
      vol_c     <= '0;
      for (int i = 0; i < 3; i++) begin
        tone_fine[i]   <= '0;
        tone_coarse[i] <= '0;
        amp[i]         <= '0;
        tone_cnt[i]    <= '0;
      end
    end else begin
      if (wr_en) begin
        case (wr_addr)
          4'd0:    tone_fine[0]   <= wr_data;
          4'd1:    tone_coarse[0] <= wr_data[3:0];
          4'd2:    tone_fine[1]   <= wr_data;
          4'd3:    tone_coarse[1] <= wr_data[3:0];
          4'd4:    tone_fine[2]   <= wr_data;
          4'd5:    tone_coarse[2] <= wr_data[3:0];
          4'd6:    noise_per      <= wr_data[NW-1:0];
          4'd7:    mixer          <= wr_data[5:0];
          4'd8:    amp[0]         <= wr_data[3:0];
          4'd9:    amp[1]         <= wr_data[3:0];
          4'd10:   amp[2]         <= wr_data[3:0];
          default: ;
        endcase
      end

      if (ena) pre_cnt <= tick_c ? '0 : pre_cnt + PW'(1);
      if (tick_c) ntick_tgl <= ~ntick_tgl;

      for (int i = 0; i < 3; i++) begin
        if (tick_c) begin
          if (tone_wrap_c[i]) begin
            tone_cnt[i] <= '0;
            tone[i]     <= ~tone[i];
          end else begin
            tone_cnt[i] <= tone_cnt[i] + TW'(1);
          end
        end
      end

      if (ntick_c) begin
        if (noise_wrap_c) begin
          noise_cnt <= '0;
          lfsr      <= {lfsr[0] ^ lfsr[3], lfsr[LW-1:1]};
        end else begin
          noise_cnt <= noise_cnt + NW'(1);
        end
      end

      vol_a <= ch_on_c[0] ? amp[0] : 4'd0;
      vol_b <= ch_on_c[1] ? amp[1] : 4'd0;
      vol_c <= ch_on_c[2] ? amp[2] : 4'd0;
    end
  end

endmodule

// File: tb/tb_ay8913_psg_core.sv
// Directed bench for ay8913_psg_core: reset, register map, tone timing, noise LFSR, ena freeze.
module tb_ay8913_psg_core;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] vol_a;
  logic [3:0] vol_b;
  logic [3:0] vol_c;

  int n_chk;
  int n_fail;

  ay8913_psg_core #(.PRESCALE(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .vol_a   (vol_a),
    .vol_b   (vol_b),
    .vol_c   (vol_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Edges until vol_a changes; an expired bound counts as a failure.
  task automatic wait_change(input string tag, input int bound, output int n);
    logic [3:0] v;
    v = vol_a;
    n = 0;
    do begin
      step();
      n++;
    end while (vol_a === v && n < bound);
    if (vol_a === v) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: timeout observed no change expected change within %0d", tag, bound);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 4'($urandom_range(0, 10));
    wr_data = 8'($urandom);
    step();
    wr_addr = 4'd9;
    wr_data = 8'hFF;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    int n;
    int changes;
    logic [3:0] v;
    logic [3:0] v1;
    logic [3:0] v2;
    logic [16:0] lf;
    logic prev_noise;

    n_chk   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    ena     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    // Reset with writes pending
    do_reset();
    chk("rst_vol_a", int'(vol_a), 0);
    chk("rst_vol_b", int'(vol_b), 0);
    chk("rst_vol_c", int'(vol_c), 0);
    rst_n = 1'b1;
    wr(4'd8, 8'h0F);
    chk("r8_same_edge", int'(vol_a), 0);
    step();
    chk("r8_next_edge", int'(vol_a), 15);
    chk("r9_reset_write_dropped", int'(vol_b), 0);

    // Amplitudes B/C, then ignored addresses 11..15
    wr(4'd9, 8'h05);
    wr(4'd10, 8'h07);
    step();
    chk("amp_b", int'(vol_b), 5);
    chk("amp_c", int'(vol_c), 7);
    for (int a = 11; a < 16; a++) wr(4'(a), 8'h00);
    wr(4'd12, 8'hFF);
    step();
    step();
    chk("ign_vol_a", int'(vol_a), 15);
    chk("ign_vol_b", int'(vol_b), 5);
    chk("ign_vol_c", int'(vol_c), 7);

    // Tone A, period 1: 8-cycle levels
    wr(4'd0, 8'h01);
    wr(4'd1, 8'h00);
    wr(4'd7, 8'h3E);
    wait_change("tone1_sync", 20, n);
    wait_change("tone1_run_a", 20, n);
    chk("tone1_run_a", n, 8);
    v1 = vol_a;
    wait_change("tone1_run_b", 20, n);
    chk("tone1_run_b", n, 8);
    v2 = vol_a;
    chk("tone1_levels", int'(v1 ^ v2), 15);

    // Period 0 behaves as period 1
    wr(4'd0, 8'h00);
    wait_change("tone0_sync", 20, n);
    wait_change("tone0_run", 20, n);
    chk("tone0_run", n, 8);

    // Period 0xFFF (coarse upper nibble dropped)
    wr(4'd1, 8'hFF);
    wr(4'd0, 8'hFF);
    wait_change("fff_sync", 33000, n);
    wait_change("fff_run", 33000, n);
    chk("fff_run", n, 32760);

    // 800 cycles in (cnt=100), shrink to 2: wrap on next tick
    v = vol_a;
    changes = 0;
    repeat (800) begin
      step();
      if (vol_a !== v) changes++;
    end
    chk("fff_hold", changes, 0);
    wr(4'd1, 8'h00);
    wr(4'd0, 8'h02);
    wait_change("shrink_wrap", 20, n);
    chk("shrink_wrap", n, 6);
    wait_change("period2_run", 40, n);
    chk("period2_run", n, 16);

    // ena low for 50 cycles 5 cycles into a 16-cycle level
    repeat (5) step();
    ena = 1'b0;
    v = vol_a;
    changes = 0;
    repeat (50) begin
      step();
      if (vol_a !== v) changes++;
    end
    chk("freeze_hold", changes, 0);
    ena = 1'b1;
    wait_change("freeze_resume", 40, n);
    chk("freeze_resume", n, 11);

    // Mixer/amplitude writes still propagate while frozen
    ena = 1'b0;
    wr(4'd7, 8'h3F);
    wr(4'd8, 8'h07);
    chk("frozen_amp_old", int'(vol_a), 15);
    step();
    chk("frozen_amp_new", int'(vol_a), 7);
    ena = 1'b1;

    // Mid-operation reset, then noise on A only with a reference LFSR
    do_reset();
    chk("rst2_vol_a", int'(vol_a), 0);
    chk("rst2_vol_b", int'(vol_b), 0);
    rst_n = 1'b1;
    lf = 17'h00001;
    for (int k = 1; k <= 640; k++) begin
      wr_en = (k <= 3);
      case (k)
        1:       begin wr_addr = 4'd6; wr_data = 8'h01; end
        2:       begin wr_addr = 4'd7; wr_data = 8'h37; end
        default: begin wr_addr = 4'd8; wr_data = 8'h09; end
      endcase
      prev_noise = lf[0];
      step();
      wr_en = 1'b0;
      if (k % 16 == 0) lf = {lf[0] ^ lf[3], lf[16:1]};
      if (k == 16) chk("lfsr_step1_bit0", int'(lf[0]), 0);
      if (k >= 4) chk($sformatf("noise_k%0d", k), int'(vol_a), prev_noise ? 9 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
